// File: rtl/tdm_mac.sv
// Time-division multiplexed multiply-accumulate: per-channel burst sums of signed products.
// Optional macro TDM_MAC_SAT_EN selects sticky saturating accumulation instead of wrap-around.
module tdm_mac #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned ACC_WIDTH = 2*WIDTH+8,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     din_a,
  input  logic signed [WIDTH-1:0]     din_b,
  input  logic [CH_W-1:0]             din_ch,
  input  logic                        din_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] dout_acc,
  output logic [CH_W-1:0]             dout_ch
);

  localparam int unsigned PW = 2*WIDTH;

  typedef struct packed {
    logic                 valid;
    logic                 last;
    logic [CH_W-1:0]      ch;
    logic signed [PW-1:0] prod;
  } s1_t;

  s1_t                         s1_q;
  logic signed [ACC_WIDTH-1:0] acc_q [CHANNELS];
  logic                        stall_c;
  logic                        ch_ok_c;
  logic signed [PW-1:0]        prod_c;
  logic signed [ACC_WIDTH-1:0] acc_sel_c;
  logic signed [ACC_WIDTH-1:0] sum_c;

  assign stall_c   = out_valid && !out_ready;
  assign in_ready  = !stall_c;
  // Out-of-range channels are accepted but never enter the accumulate stage.
  assign ch_ok_c   = ({1'b0, din_ch} < (CH_W+1)'(CHANNELS));
  assign prod_c    = din_a * din_b;
  assign acc_sel_c = acc_q[s1_q.ch];

`ifdef TDM_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [CHANNELS-1:0]       sat_q;
  logic signed [ACC_WIDTH:0] wide_c;
  logic                      ovf_c;

  assign wide_c = (ACC_WIDTH+1)'(acc_sel_c) + (ACC_WIDTH+1)'(s1_q.prod);
  assign ovf_c  = wide_c[ACC_WIDTH] ^ wide_c[ACC_WIDTH-1];

  // A saturated channel holds its clamped value until the burst closes.
  always_comb begin
    sum_c = wide_c[ACC_WIDTH-1:0];
    if (sat_q[s1_q.ch]) begin
      sum_c = acc_sel_c;
    end else if (ovf_c) begin
      sum_c = wide_c[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_q <= '0;
    end else if (!stall_c && s1_q.valid) begin
      if (s1_q.last) begin
        sat_q[s1_q.ch] <= 1'b0;
      end else if (ovf_c) begin
        sat_q[s1_q.ch] <= 1'b1;
      end
    end
  end
`else
  assign sum_c = acc_sel_c + ACC_WIDTH'(s1_q.prod);
`endif

  // Stage 1 registers the product; stage 2 does the read-modify-write and result load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= '0;
      out_valid <= 1'b0;
      dout_acc  <= '0;
      dout_ch   <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        acc_q[i] <= '0;
      end
    end else if (!stall_c) begin
      s1_q.valid <= in_valid && ch_ok_c;
      s1_q.last  <= din_last;
      s1_q.ch    <= din_ch;
      s1_q.prod  <= prod_c;
      out_valid  <= s1_q.valid && s1_q.last;
      if (s1_q.valid) begin
        acc_q[s1_q.ch] <= s1_q.last ? '0 : sum_c;
        if (s1_q.last) begin
          dout_acc <= sum_c;
          dout_ch  <= s1_q.ch;
        end
      end
    end
  end

endmodule

// File: doc/tdm_mac.md
TDM_MAC -- requirements
Module: tdm_mac

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width, signed two's complement.
REQ-002 SHALL have parameter CHANNELS, default 4: number of independent TDM accumulator channels, >= 1.
REQ-003 SHALL have parameter ACC_WIDTH, default 2*WIDTH+8: accumulator and result width, >= 2*WIDTH.
REQ-004 SHALL derive CH_W = max(1, $clog2(CHANNELS)) for the channel-index width.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1: input sample valid.
REQ-008 SHALL have port in_ready, output, 1: block can accept a sample.
REQ-009 SHALL have ports din_a and din_b, input, WIDTH each: signed operands.
REQ-010 SHALL have port din_ch, input, CH_W: channel the sample belongs to.
REQ-011 SHALL have port din_last, input, 1: last sample of the burst for din_ch.
REQ-012 SHALL have port out_valid, output, 1: result valid.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-014 SHALL have port dout_acc, output, ACC_WIDTH: signed burst sum.
REQ-015 SHALL have port dout_ch, output, CH_W: channel of dout_acc.

Function
REQ-016 SHALL accept a sample in a cycle where in_valid && in_ready.
REQ-017 SHALL define stall = out_valid && !out_ready, and SHALL drive in_ready = !stall combinationally.
REQ-018 SHALL hold all pipeline registers, accumulators and outputs unchanged while stall is high.
REQ-019 Stage 1 SHALL register the full 2*WIDTH signed product together with ch, last and a valid bit.
REQ-020 Stage 2 SHALL add the sign-extended product to acc[ch] in one read-modify-write cycle, so back-to-back samples on the same channel need no bubble.
REQ-021 When the stage-2 sample has last=1, SHALL load dout_acc with acc[ch] plus the product, set dout_ch = ch and out_valid = 1, and clear acc[ch] to 0 in the same cycle.
REQ-022 Latency: result visible, out_valid high, 2 cycles after acceptance of the last sample when no stall occurs; throughput 1 sample per cycle.
REQ-023 When out_valid && out_ready and no new result is loaded, SHALL deassert out_valid next cycle; a new result MAY load in that same handshake cycle.
REQ-024 dout_acc and dout_ch SHALL stay stable while out_valid && !out_ready.
REQ-025 SHALL accept and discard a sample with din_ch >= CHANNELS, leaving every accumulator untouched and emitting no result.
REQ-026 A burst of a single sample with last=1 SHALL produce result = product.
REQ-027 Without the saturation feature, accumulation SHALL wrap modulo 2^ACC_WIDTH.
REQ-028 Interleaved channels SHALL accumulate independently in any order.

Reset
REQ-029 While rst_n = 0 at a clock edge, SHALL clear all accumulators, pipeline valid bits, out_valid, dout_acc and dout_ch to 0.
REQ-030 in_ready SHALL be 1 in the first cycle after reset.
REQ-031 Reset mid-burst SHALL discard all partial sums and in-flight samples with no output.

Configuration
REQ-032 With macro TDM_MAC_SAT_EN defined, stage 2 and the result SHALL saturate to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; saturation is sticky until the burst's result is emitted.
REQ-033 Without TDM_MAC_SAT_EN, SHALL use wrap-around arithmetic per REQ-027, with no saturation logic.

Verification
REQ-034 WIDTH=8, ch0 samples (3,4), (-2,5), (127,127) with last -> dout_acc=16131, dout_ch=0, out_valid 2 cycles after last is accepted.
REQ-035 Interleave ch1 (-128,-128) x3 with last on the third, and ch2 (1,-1) with last, every cycle -> ch2 result -1, then ch1 result 49152, in acceptance order with no bubbles.
REQ-036 Result pending, out_ready low 5 cycles -> in_ready low 5 cycles, dout_acc/dout_ch stable, no sample lost; results correct after release.
REQ-037 ACC_WIDTH=16, ch0 (127,127) x3 with last -> dout_acc=-17149 without the macro; 32767 with TDM_MAC_SAT_EN.
REQ-038 ch3 (5,5) x2, rst_n low 1 cycle, then ch3 (2,3) with last -> single result 6; no output for the aborted samples.
